multicycle_control_fsm: RTL

- Sequencing controller that runs the existing RV32I datapath blocks (PC, instruction/data memory, register file, ALU, immediate generator, muxes) as a multi-cycle machine over one shared memory port.
- Each instruction is split into FETCH / DECODE / EXECUTE / MEM / WRITEBACK steps, with the memory handshake honoured at every access.
- Drives the per-step mux selects and write enables, and keeps retired-instruction and cycle counters.

---
 rtl/multicycle_control_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: steps each instruction through
// fetch/decode/execute/memory/writeback over a single shared memory port,
// drives datapath selects and write enables, and keeps perf counters.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_write,
    output logic             oldpc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_source,
    output logic             instr_done,
    output logic             illegal_instr,
    output logic             mem_fault,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] cycles_q;
    logic             waiting_c;
    logic             timeout_c;
    logic             pc_write;
    logic             pc_write_cond;

    // States that hold a memory access open while waiting for mem_ready
    assign waiting_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // Access has already waited TIMEOUT cycles and is still not ready
    assign timeout_c = (TIMEOUT != 0) && waiting_c && !mem_ready
                       && (timer_q == TMR_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory wait timer: counts consecutive stalled cycles of one access
    always_ff @(posedge clk) begin
        if (rst || timeout_c || !waiting_c || mem_ready || (TIMEOUT == 0)) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    // Cycle and retired-instruction counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            cycles_q  <= cycles_q + CNT_W'(1);
            instret_q <= instret_q + CNT_W'(instr_done);
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)      state_d = S_WB_MEM;
                else if (timeout_c) state_d = S_FETCH;
            end
            S_MEM_WR: begin
                if (mem_ready || timeout_c) state_d = S_FETCH;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Moore output decode; fetch loads are qualified by mem_ready, all gated by rst
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        oldpc_write   = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem_fault     = 1'b0;
        if (!rst) begin
            mem_fault = timeout_c;
            case (state_q)
                S_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = 2'b01;
                    ir_write    = mem_ready;
                    oldpc_write = mem_ready;
                    pc_write    = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    illegal_instr = !((opcode == OP_R) || (opcode == OP_I) ||
                                      (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                                      (opcode == OP_BRANCH));
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_WB_ALU: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b01;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                    instr_done    = 1'b1;
                end
                default: mem_fault = 1'b0;
            endcase
        end
        pc_en = pc_write | (pc_write_cond & zero);
    end

    // Debug and counter views read as zero while reset is held
    assign state   = rst ? 4'd0 : state_q;
    assign instret = rst ? '0 : instret_q;
    assign cycles  = rst ? '0 : cycles_q;

endmodule
